// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO stream reader: default word width, the
// fixed output-buffer depth, occupancy counter width and the reader FSM
// state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int READER_WIDTH     = 8;  // default data word width
  localparam int READER_BUF_DEPTH = 2;  // output buffer entries (fixed)
  localparam int OCC_W            = 2;  // holds occupancy 0..2

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } reader_state_t;

endpackage

// File: rtl/rd_skid_buf.sv
// ---------------------------------------------------------------------------
// rd_skid_buf
// Two-entry in-order output buffer. Words enter at the tail and leave from
// the head; a simultaneous push and pop advances the head while the new word
// fills the freed slot.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   i_push, i_data write i_data at the tail this edge
//   i_pop          head word consumed this edge (only asserted when occ!=0)
//   i_clear        discard all entries this edge (a pop is still honoured)
//   o_head         head entry, registered; holds its value when empty
//   o_occ          number of valid entries, 0..2
// ---------------------------------------------------------------------------
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = READER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_head,
  output logic [OCC_W-1:0] o_occ
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [OCC_W-1:0] r_occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      // Head: shift the tail forward on a pop from a full buffer, otherwise
      // the incoming word becomes the head when the buffer is (or is about
      // to become) empty.
      if (i_pop && (r_occ == 2'd2)) begin
        r_head <= r_tail;
      end else if (i_push && ((r_occ == 2'd0) || ((r_occ == 2'd1) && i_pop))) begin
        r_head <= i_data;
      end

      // Tail: written when the head slot stays occupied after this edge.
      if (i_push && (((r_occ == 2'd1) && !i_pop) || ((r_occ == 2'd2) && i_pop))) begin
        r_tail <= i_data;
      end

      if (i_clear) begin
        r_occ <= '0;
      end else begin
        r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
      end
    end
  end

  assign o_head = r_head;
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
// Read-side consumer for a single-clock synchronous FIFO with a one-cycle
// registered read. Issues reads, absorbs the read latency and presents the
// words as a valid/ready stream through a 2-entry buffer, with a flush
// control and a protocol-error pulse.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   fifo_empty_i   FIFO empty flag
//   fifo_rdata_i   FIFO read data, valid the cycle after a read
//   fifo_error_i   FIFO error flag
//   fifo_rd_en_o   FIFO read request
//   m_data_o       stream data (buffer head)
//   m_valid_o      stream valid
//   m_ready_i      downstream accept
//   flush_i        discard buffered and in-flight data
//   proto_err_o    one-cycle pulse: FIFO error while a read was landing
//   word_cnt_o     (FIFO_READER_WORD_COUNT_EN only) wrapping pop counter
// Build option: define FIFO_READER_WORD_COUNT_EN to add word_cnt_o.
// ---------------------------------------------------------------------------
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH     = READER_WIDTH,
  parameter int BUF_DEPTH = READER_BUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  input  logic             fifo_error_i,
  output logic             fifo_rd_en_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  input  logic             flush_i,
  output logic             proto_err_o
`ifdef FIFO_READER_WORD_COUNT_EN
  ,
  output logic [15:0]      word_cnt_o
`endif
);

  if (BUF_DEPTH != READER_BUF_DEPTH) begin : g_bad_depth
    $error("fifo_stream_reader: BUF_DEPTH must be 2");
  end

  reader_state_t    r_state;
  logic             r_inflight;
  logic             r_proto_err;

  logic [OCC_W-1:0] w_occ;
  logic [OCC_W-1:0] w_pending;
  logic [WIDTH-1:0] w_head;
  logic             w_pop;
  logic             w_push;
  logic             w_rd_en;

  assign m_valid_o = (w_occ != '0);
  assign m_data_o  = w_head;
  assign w_pop     = m_valid_o & m_ready_i;

  // Buffered words plus the one possibly in flight; never exceeds 2.
  assign w_pending = w_occ + {{(OCC_W-1){1'b0}}, r_inflight};

  // A read is allowed when a slot is guaranteed free at landing time. The
  // rst term keeps the request low while reset is held.
  assign w_rd_en = !rst && !fifo_empty_i && !flush_i && (r_state == RUN) &&
                   ((w_pending <= 2'd1) || ((w_pending == 2'd2) && w_pop));
  assign fifo_rd_en_o = w_rd_en;

  // Landing word is dropped on flush or when the FIFO flags an error.
  assign w_push = r_inflight && !flush_i && !fifo_error_i && (r_state == RUN);

  rd_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (fifo_rdata_i),
    .i_pop   (w_pop),
    .i_clear (flush_i),
    .o_head  (w_head),
    .o_occ   (w_occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_inflight  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_inflight  <= w_rd_en;
      r_proto_err <= r_inflight && fifo_error_i;
      case (r_state)
        RUN: begin
          if (flush_i && r_inflight) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          r_state <= RUN;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign proto_err_o = r_proto_err;

`ifdef FIFO_READER_WORD_COUNT_EN
  logic [15:0] r_word_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_cnt <= '0;
    end else if (w_pop) begin
      r_word_cnt <= r_word_cnt + 16'd1;
    end
  end

  assign word_cnt_o = r_word_cnt;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
// Directed bench for fifo_stream_reader with a behavioural FIFO (queue plus
// one-cycle registered read) and a scoreboard of words expected downstream.
// Define FIFO_READER_WORD_COUNT_EN to also exercise word_cnt_o.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty_i;
  logic [7:0] fifo_rdata_i;
  logic       fifo_error_i;
  logic       fifo_rd_en_o;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic       flush_i;
  logic       proto_err_o;
`ifdef FIFO_READER_WORD_COUNT_EN
  logic [15:0] word_cnt_o;
`endif

  fifo_stream_reader #(.WIDTH(8), .BUF_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_error_i (fifo_error_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .flush_i      (flush_i),
    .proto_err_o  (proto_err_o)
`ifdef FIFO_READER_WORD_COUNT_EN
    ,
    .word_cnt_o   (word_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         n_pops = 0;
  bit         quiet = 1'b0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic       s_rd, s_valid, s_perr;
  logic [7:0] s_data;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Put a word into the model FIFO; optionally expect it downstream.
  task automatic load(input logic [7:0] w, input bit expect_out);
    fifo_q.push_back(w);
    if (expect_out) exp_q.push_back(w);
    fifo_empty_i = 1'b0;
  endtask

  // One clock cycle: sample on the falling edge, scoreboard pops, then model
  // the FIFO's registered read just after the rising edge.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    s_rd    = fifo_rd_en_o;
    s_valid = m_valid_o;
    s_data  = m_data_o;
    s_perr  = proto_err_o;
    if (prev_stall && s_valid) chk("hold_stable", s_data, prev_data);
    if (s_valid && m_ready_i) begin
      n_pops++;
      chk("pop_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pop_data", s_data, e);
      end
      if (!quiet) $display("pop data=%02h exp_left=%0d", s_data, exp_q.size());
    end
    prev_stall = s_valid && !m_ready_i;
    prev_data  = s_data;
    @(posedge clk);
    #1;
    if (s_rd) begin
      chk("rd_not_empty", fifo_q.size() != 0, 1'b1);
      if (fifo_q.size() != 0) fifo_rdata_i = fifo_q.pop_front();
    end
    fifo_empty_i = (fifo_q.size() == 0);
  endtask

  initial begin
    int         rd_cnt;
    int         perr_cnt;
    logic [7:0] rd_vec;
    logic [7:0] val_vec;

    rst          = 1'b1;
    fifo_empty_i = 1'b1;
    fifo_rdata_i = 8'h00;
    fifo_error_i = 1'b0;
    m_ready_i    = 1'b0;
    flush_i      = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_rd_en", fifo_rd_en_o, 1'b0);
    chk("rst_valid", m_valid_o, 1'b0);
    chk("rst_data", m_data_o, 8'h00);
    chk("rst_perr", proto_err_o, 1'b0);
`ifdef FIFO_READER_WORD_COUNT_EN
    chk("rst_cnt", word_cnt_o, 16'd0);
`endif
    rst = 1'b0;

    // 1: three words, downstream always ready
    m_ready_i = 1'b1;
    load(8'h11, 1); load(8'h22, 1); load(8'h33, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      rd_vec[i]  = s_rd;
      val_vec[i] = s_valid;
    end
    chk("t1_rd_pattern", rd_vec, 8'b0000_0111);
    chk("t1_valid_pattern", val_vec, 8'b0001_1100);
    chk("t1_drained", exp_q.size(), 0);

    // 2: backpressure, exactly two reads fill the buffer
    m_ready_i = 1'b0;
    load(8'h11, 1); load(8'h22, 1); load(8'h33, 1); load(8'h44, 1); load(8'h55, 1);
    rd_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      rd_cnt += int'(s_rd);
    end
    chk("t2_reads_stalled", rd_cnt, 2);
    chk("t2_valid_stalled", s_valid, 1'b1);
    chk("t2_head_stalled", s_data, 8'h11);
    m_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("t2_drained", exp_q.size(), 0);
    chk("t2_fifo_empty", fifo_q.size(), 0);

    // 3: flush while a read is landing and one word is buffered
    m_ready_i = 1'b0;
    load(8'hA1, 0);
    tick();
    tick();
    load(8'hA2, 0); load(8'hA3, 1);
    tick();
    chk("t3_rd_before_flush", s_rd, 1'b1);
    flush_i = 1'b1;
    tick();
    chk("t3_valid_at_flush", s_valid, 1'b1);
    flush_i = 1'b0;
    tick();
    chk("t3_valid_after_flush", s_valid, 1'b0);
    chk("t3_rd_held_in_flush", s_rd, 1'b0);
    m_ready_i = 1'b1;
    tick();
    chk("t3_rd_resumed", s_rd, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_fifo_empty", fifo_q.size(), 0);

    // 4a: FIFO error with nothing in flight is ignored
    fifo_error_i = 1'b1;
    tick();
    fifo_error_i = 1'b0;
    tick();
    chk("t4_err_ignored", s_perr, 1'b0);

    // 4b: FIFO error in the landing cycle drops that word
    load(8'hB1, 0); load(8'hB2, 1);
    tick();
    fifo_error_i = 1'b1;
    tick();
    fifo_error_i = 1'b0;
    perr_cnt = 0;
    tick();
    chk("t4_perr_pulse", s_perr, 1'b1);
    perr_cnt += int'(s_perr);
    for (int i = 0; i < 5; i++) begin
      tick();
      perr_cnt += int'(s_perr);
    end
    chk("t4_perr_one_cycle", perr_cnt, 1);
    chk("t4_drained", exp_q.size(), 0);

    // 5: asynchronous reset mid-stream (word buffered, read in flight)
    load(8'hD1, 1); load(8'hD2, 1); load(8'hD3, 1);
    load(8'hD4, 1); load(8'hD5, 1); load(8'hD6, 1);
    for (int i = 0; i < 4; i++) tick();
    #1;
    rst = 1'b1;
    #1;
    chk("t5_async_rd_en", fifo_rd_en_o, 1'b0);
    chk("t5_async_valid", m_valid_o, 1'b0);
    chk("t5_async_data", m_data_o, 8'h00);
    chk("t5_async_perr", proto_err_o, 1'b0);
    // buffered D3 and in-flight D4 are lost; D5, D6 still sit in the FIFO
    exp_q.delete();
    exp_q.push_back(8'hD5);
    exp_q.push_back(8'hD6);
    n_pops = 0;
    prev_stall = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_fifo_empty", fifo_q.size(), 0);

`ifdef FIFO_READER_WORD_COUNT_EN
    // 6: pop counter wraps and ignores flush
    rst = 1'b1;
    n_pops = 0;
    tick();
    rst = 1'b0;
    chk("t6_cnt_cleared", word_cnt_o, 16'd0);
    quiet = 1'b1;
    for (int i = 0; i < 70000; i++) load(i[7:0], 1);
    for (int i = 0; i < 70010; i++) tick();
    quiet = 1'b0;
    chk("t6_pops_seen", n_pops, 70000);
    chk("t6_cnt_wrap", word_cnt_o, 16'd4464);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick();
    chk("t6_cnt_after_flush", word_cnt_o, 16'd4464);
    chk("t6_drained", exp_q.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
